// File: rtl/clkdiv_prog_multi_pkg.sv
// Shared types and helpers for the multi-channel programmable clock divider.
// Update-handshake state encoding and the effective high-time clamp.
package clkdiv_prog_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PEND = 2'b01,
    ST_HOLD = 2'b11,
    ST_DONE = 2'b10
  } st_e;

  // Zero high time selects half the ratio; an oversized one still leaves one low cycle.
  function automatic logic [31:0] eff_high(input logic [31:0] d, input logic [31:0] h);
    if (h == 32'd0)     return d >> 1;
    else if (h >= d)    return d - 32'd1;
    else                return h;
  endfunction

endpackage

// File: rtl/clkdiv_prog_multi_chan.sv
// One divider channel: counter, registered output and the shadow-register
// update handshake that swaps settings only on a period boundary.
module clkdiv_chan
  import clkdiv_prog_multi_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         in,
  input  logic         rst_n,
  input  logic [n-1:0] div,
  input  logic [n-1:0] hi,
  input  logic         upd,
  input  logic         sync,
  output logic         ack,
  output logic         reset,
  output logic         out
);

  st_e          st_q, st_d;
  logic [n-1:0] seldiv_q, seldiv_d;
  logic [n-1:0] selhi_q, selhi_d;
  logic [n-1:0] shdiv_q, shdiv_d;
  logic [n-1:0] shhi_q, shhi_d;
  logic [n-1:0] cnt_q, cnt_d;
  logic         out_q, out_d;

  logic         en, pe, en_d;
  logic [n-1:0] eh_d;

  assign en = (seldiv_q >= n'(2));
  assign pe = !en || (cnt_q == seldiv_q - n'(1));

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    st_d     = st_q;
    seldiv_d = seldiv_q;
    selhi_d  = selhi_q;
    shdiv_d  = shdiv_q;
    shhi_d   = shhi_q;
    cnt_d    = (pe || sync) ? '0 : cnt_q + n'(1);

    case (st_q)
      ST_IDLE: begin
        if (upd) begin
          shdiv_d = div;
          shhi_d  = hi;
          st_d    = ST_PEND;
        end
      end
      ST_PEND: begin
        if (pe || sync) begin
          seldiv_d = shdiv_q;
          selhi_d  = shhi_q;
          cnt_d    = '0;
          st_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (pe || sync) st_d = ST_DONE;
      end
      ST_DONE: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase

    // Output is computed from post-edge values so a rise lands on the edge where cnt hits 0.
    en_d  = (seldiv_d >= n'(2));
    eh_d  = n'(eff_high(32'(seldiv_d), 32'(selhi_d)));
    out_d = en_d && (cnt_d < eh_d);
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge in or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= ST_IDLE;
      seldiv_q <= '0;
      selhi_q  <= '0;
      shdiv_q  <= '0;
      shhi_q   <= '0;
      cnt_q    <= '0;
      out_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      seldiv_q <= seldiv_d;
      selhi_q  <= selhi_d;
      shdiv_q  <= shdiv_d;
      shhi_q   <= shhi_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  assign ack   = (st_q == ST_DONE);
  assign reset = (st_q == ST_PEND) || (st_q == ST_HOLD);
  assign out   = out_q;

endmodule

// File: rtl/clkdiv_prog_multi.sv
// Multi-channel programmable clock divider: ch independent channels on one
// source clock, sharing a common phase-align (sync) input.
module clkdiv_prog_multi #(
  parameter int n  = 8,
  parameter int ch = 2
) (
  input  logic            in,
  input  logic            rst_n,
  input  logic [ch*n-1:0] div,
  input  logic [ch*n-1:0] hi,
  input  logic [ch-1:0]   upd,
  input  logic            sync,
  output logic [ch-1:0]   ack,
  output logic [ch-1:0]   reset,
  output logic [ch-1:0]   out
);

  for (genvar g = 0; g < ch; g++) begin : g_chan
    clkdiv_chan #(.n(n)) u_chan (
      .in    (in),
      .rst_n (rst_n),
      .div   (div[g*n +: n]),
      .hi    (hi[g*n +: n]),
      .upd   (upd[g]),
      .sync  (sync),
      .ack   (ack[g]),
      .reset (reset[g]),
      .out   (out[g])
    );
  end

endmodule

// File: tb/tb_clkdiv_prog_multi.sv
// Scoreboarded bench for clkdiv_prog_multi: update requests queue the expected
// reset-high length; a monitor checks it on each ack pulse.
module tb_clkdiv_prog_multi;

  localparam int N  = 8;
  localparam int CH = 2;

  typedef struct {
    int c;
    int cyc;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [CH*N-1:0] div;
  logic [CH*N-1:0] hi;
  logic [CH-1:0]   upd;
  logic            sync;
  logic [CH-1:0]   ack_w;
  logic [CH-1:0]   reset_w;
  logic [CH-1:0]   out_w;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  int   rhi[CH];

  int   cyc = 0;
  int   last_rise = -1;
  int   min_iv = 1000;
  int   max_iv = 0;

  clkdiv_prog_multi #(.n(N), .ch(CH)) dut (
    .in    (clk),
    .rst_n (rst_n),
    .div   (div),
    .hi    (hi),
    .upd   (upd),
    .sync  (sync),
    .ack   (ack_w),
    .reset (reset_w),
    .out   (out_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: counts reset-high cycles per channel, compares on ack.
  initial begin
    for (int c = 0; c < CH; c++) rhi[c] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int c = 0; c < CH; c++) rhi[c] = 0;
      end else begin
        for (int c = 0; c < CH; c++) begin
          if (reset_w[c]) rhi[c]++;
          if (ack_w[c]) begin
            if (sb_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_ack: got ack on ch%0d expected none", c);
            end else begin
              exp_t e;
              e = sb_q.pop_front();
              check("ack_chan", c, e.c);
              check("reset_len", rhi[c], e.cyc);
            end
            rhi[c] = 0;
          end
        end
      end
    end
  end

  // Rise-to-rise interval tracker on channel 1.
  initial begin
    logic prev1;
    prev1 = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (out_w[1] && !prev1) begin
        if (last_rise >= 0) begin
          if (cyc - last_rise < min_iv) min_iv = cyc - last_rise;
          if (cyc - last_rise > max_iv) max_iv = cyc - last_rise;
        end
        last_rise = cyc;
      end
      prev1 = out_w[1];
    end
  end

  task automatic do_upd(input int c, input int d, input int h, input bit with_sync,
                        input int exp_cyc);
    exp_t e;
    @(negedge clk);
    div[c*N +: N] = d[N-1:0];
    hi[c*N +: N]  = h[N-1:0];
    upd[c]        = 1'b1;
    sync          = with_sync;
    if (exp_cyc >= 0) begin
      e.c   = c;
      e.cyc = exp_cyc;
      sb_q.push_back(e);
    end
    @(negedge clk);
    upd  = '0;
    sync = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    check("idle_timeout", sb_q.size(), 0);
  endtask

  task automatic measure(input int c, input int exp_hi, input int exp_lo);
    logic prev;
    int   hcnt, lcnt, i;
    prev = out_w[c];
    for (i = 0; i < 64; i++) begin
      @(negedge clk);
      if (out_w[c] && !prev) break;
      prev = out_w[c];
    end
    check("rise_timeout", int'(i < 64), 1);
    hcnt = 1;
    @(negedge clk);
    while (out_w[c] && hcnt < 64) begin
      hcnt++;
      @(negedge clk);
    end
    lcnt = 1;
    @(negedge clk);
    while (!out_w[c] && lcnt < 64) begin
      lcnt++;
      @(negedge clk);
    end
    check("high_time", hcnt, exp_hi);
    check("low_time", lcnt, exp_lo);
  endtask

  task automatic stays_low(input int c);
    int highs;
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (out_w[c]) highs++;
    end
    check("disabled_out", highs, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    div   = '0;
    hi    = '0;
    upd   = '0;
    sync  = 1'b0;
    #1;
    check("rst_out", int'(out_w), 0);
    check("rst_reset", int'(reset_w), 0);
    check("rst_ack", int'(ack_w), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stays_low(0);

    // Default duty, ratio 4, from disabled: 1 pend + 4 hold.
    do_upd(0, 4, 0, 1'b0, 5);
    wait_idle();
    measure(0, 2, 2);

    // Updates issued with sync: pend lasts one old period, hold one new period.
    do_upd(0, 5, 0, 1'b1, 4 + 5);
    wait_idle();
    measure(0, 2, 3);
    do_upd(0, 6, 1, 1'b1, 5 + 6);
    wait_idle();
    measure(0, 1, 5);
    do_upd(0, 6, 9, 1'b1, 6 + 6);
    wait_idle();
    measure(0, 5, 1);

    // Disable via ratio 1, then ratio 0.
    do_upd(0, 1, 0, 1'b1, 6 + 1);
    wait_idle();
    stays_low(0);
    do_upd(0, 0, 0, 1'b0, 2);
    wait_idle();
    stays_low(0);

    // Mid-period update on ch1: ratio 8 -> 3 requested so cnt reads 2 in PEND.
    do_upd(1, 8, 0, 1'b0, 1 + 8);
    wait_idle();
    for (int i = 0; i < 32 && out_w[1]; i++) @(negedge clk);
    check("low_wait", int'(out_w[1]), 0);
    sync      = 1'b1;
    last_rise = -1;
    min_iv    = 1000;
    max_iv    = 0;
    @(negedge clk);
    sync = 1'b0;
    do_upd(1, 3, 0, 1'b0, 6 + 3);
    repeat (24) @(negedge clk);
    wait_idle();
    check("min_period", min_iv, 3);
    check("max_period", max_iv, 8);

    // Phase alignment: ch0 ratio 3, ch1 ratio 4.
    do_upd(0, 3, 0, 1'b1, 1 + 3);
    wait_idle();
    do_upd(1, 4, 0, 1'b1, 3 + 4);
    wait_idle();
    @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      check("align_ch0", int'(out_w[0]), int'((k % 3) < 1));
      check("align_ch1", int'(out_w[1]), int'((k % 4) < 2));
      @(negedge clk);
    end

    // Asynchronous reset while ch0 is in HOLD.
    do_upd(0, 8, 0, 1'b0, -1);
    repeat (3) @(negedge clk);
    check("hold_reset", int'(reset_w[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out", int'(out_w), 0);
    check("async_reset", int'(reset_w), 0);
    check("async_ack", int'(ack_w), 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_upd(0, 2, 0, 1'b0, 1 + 2);
    wait_idle();
    measure(0, 1, 1);
    stays_low(1);

    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
